// File: rtl/power_sample_ctrl.sv
// power_sample_ctrl: periodic sampler for an external I2C read engine.
// Waits INTERVAL cycles, pulses GO for GO_CYC cycles, then follows the
// engine's END_OK handshake (high->low->high) with a TMO-cycle watchdog in
// both handshake phases. Each captured word updates SAMPLE, and every
// 2^AVG_LOG2 captures produce a truncated average on AVG.
//
// Optional feature: define PSC_MINMAX_EN to track the minimum and maximum of
// each averaging window (MIN/MAX load together with AVG_VLD). When it is not
// defined, MIN and MAX are tied to zero.
//
// Ports:
//   PT_CK        clock, rising edge
//   RESET_N      asynchronous active-low reset
//   EN           run enable for periodic sampling
//   END_OK       engine idle/finished flag (high = idle)
//   DATA16       engine read word, valid while END_OK high after a read
//   GO           read request to the engine
//   SAMPLE       last raw word          SAMPLE_VLD  one-cycle update pulse
//   AVG          window average         AVG_VLD     one-cycle update pulse
//   MIN/MAX      extremes of the last completed window
//   TIMEOUT_ERR  sticky handshake-timeout flag
//   ST           current state encoding
module power_sample_ctrl #(
  parameter int AVG_LOG2 = 3,
  parameter int INTERVAL = 1000,
  parameter int GO_CYC   = 4,
  parameter int TMO      = 4095
) (
  input  logic        PT_CK,
  input  logic        RESET_N,
  input  logic        EN,
  input  logic        END_OK,
  input  logic [15:0] DATA16,
  output logic        GO,
  output logic [15:0] SAMPLE,
  output logic        SAMPLE_VLD,
  output logic [15:0] AVG,
  output logic        AVG_VLD,
  output logic [15:0] MIN,
  output logic [15:0] MAX,
  output logic        TIMEOUT_ERR,
  output logic [2:0]  ST
);

  localparam int ACCW    = 16 + AVG_LOG2;
  localparam int CNTW    = AVG_LOG2 + 1;
  localparam int DLY_MAX = (INTERVAL > GO_CYC) ? INTERVAL : GO_CYC;
  localparam int DW      = $clog2(DLY_MAX + 1);
  localparam int TW      = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT = 3'd1, S_GO = 3'd2,
    S_REL  = 3'd3, S_BUSY = 3'd4, S_CAP = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [15:0]       sample_q, sample_d;
  logic              svld_q, svld_d;
  logic [15:0]       avg_q, avg_d;
  logic              avld_q, avld_d;

  logic [ACCW-1:0]   acc_sum;
  logic [CNTW-1:0]   cnt_inc;
  logic              win_done;
  logic              tmo_hit;

  assign acc_sum  = acc_q + ACCW'(DATA16);
  assign cnt_inc  = cnt_q + CNTW'(1);
  assign win_done = (cnt_inc == CNTW'(2 ** AVG_LOG2));
  // Watchdog expires only if the awaited END_OK edge has not arrived; in BUSY
  // a coincident END_OK rise wins and the conversion completes.
  assign tmo_hit  = (tmo_q == TW'(TMO - 1)) &&
                    (((state_q == S_REL) && END_OK) || ((state_q == S_BUSY) && !END_OK));

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      dly_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      svld_q   <= 1'b0;
      avg_q    <= '0;
      avld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      svld_q   <= svld_d;
      avg_q    <= avg_d;
      avld_q   <= avld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    svld_d   = 1'b0;
    avg_d    = avg_q;
    avld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!EN) err_d = 1'b0;
        if (EN && END_OK) begin
          dly_d   = DW'(INTERVAL - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!EN) state_d = S_IDLE;
        else if (dly_q == '0) begin
          dly_d   = DW'(GO_CYC - 1);
          state_d = S_GO;
        end else dly_d = dly_q - DW'(1);
      end
      S_GO: begin
        if (dly_q == '0) begin
          tmo_d   = '0;
          state_d = S_REL;
        end else dly_d = dly_q - DW'(1);
      end
      S_REL, S_BUSY: begin
        if ((state_q == S_REL) && !END_OK) begin
          tmo_d   = '0;
          state_d = S_BUSY;
        end else if ((state_q == S_BUSY) && END_OK) begin
          state_d = S_CAP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else tmo_d = tmo_q + TW'(1);
      end
      S_CAP: begin
        sample_d = DATA16;
        svld_d   = 1'b1;
        if (win_done) begin
          avg_d  = acc_sum[ACCW-1:AVG_LOG2];
          avld_d = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
        end else begin
          acc_d  = acc_sum;
          cnt_d  = cnt_inc;
        end
        if (EN) begin
          dly_d   = DW'(INTERVAL - 1);
          state_d = S_WAIT;
        end else begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PSC_MINMAX_EN
  logic [15:0] wmin_q, wmin_d, wmax_q, wmax_d;
  logic [15:0] min_q, min_d, max_q, max_d;
  logic [15:0] smin, smax;
  logic        win_drop;

  assign smin     = (DATA16 < wmin_q) ? DATA16 : wmin_q;
  assign smax     = (DATA16 > wmax_q) ? DATA16 : wmax_q;
  assign win_drop = tmo_hit || ((state_q == S_CAP) && !EN);

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      wmin_q <= 16'hFFFF;
      wmax_q <= 16'h0000;
      min_q  <= '0;
      max_q  <= '0;
    end else begin
      wmin_q <= wmin_d;
      wmax_q <= wmax_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  always_comb begin
    wmin_d = wmin_q;
    wmax_d = wmax_q;
    min_d  = min_q;
    max_d  = max_q;
    if (state_q == S_CAP) begin
      if (win_done) begin
        min_d  = smin;
        max_d  = smax;
        wmin_d = 16'hFFFF;
        wmax_d = 16'h0000;
      end else begin
        wmin_d = smin;
        wmax_d = smax;
      end
    end
    if (win_drop) begin
      wmin_d = 16'hFFFF;
      wmax_d = 16'h0000;
    end
  end

  assign MIN = min_q;
  assign MAX = max_q;
`else
  assign MIN = '0;
  assign MAX = '0;
`endif

  assign GO          = (state_q == S_GO);
  assign SAMPLE      = sample_q;
  assign SAMPLE_VLD  = svld_q;
  assign AVG         = avg_q;
  assign AVG_VLD     = avld_q;
  assign TIMEOUT_ERR = err_q;
  assign ST          = state_q;

endmodule

// File: tb/tb_power_sample_ctrl.sv
// Bench for power_sample_ctrl: an I2C-engine model answers GO requests, the
// stimulus pushes expected samples/averages into queues, and a monitor pops
// and compares on every SAMPLE_VLD / AVG_VLD. Two instances share inputs:
// u_dut averages 8 samples, u_dut0 averages 1 sample.
module tb_power_sample_ctrl;
  localparam int GO_CYC = 4;
  localparam int TMO    = 50;
  localparam int LIM    = 3000;
`ifdef PSC_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, end_ok = 1'b1;
  logic [15:0] data16 = '0;
  logic        go, svld, avld, terr;
  logic [15:0] sample, avg, mn, mx;
  logic [2:0]  st;
  logic        go0, svld0, avld0, terr0;
  logic [15:0] sample0, avg0, mn0, mx0;
  logic [2:0]  st0;

  always #5 clk = ~clk;

  power_sample_ctrl #(.AVG_LOG2(3), .INTERVAL(10), .GO_CYC(GO_CYC), .TMO(TMO)) u_dut (
    .PT_CK(clk), .RESET_N(rst_n), .EN(en), .END_OK(end_ok), .DATA16(data16),
    .GO(go), .SAMPLE(sample), .SAMPLE_VLD(svld), .AVG(avg), .AVG_VLD(avld),
    .MIN(mn), .MAX(mx), .TIMEOUT_ERR(terr), .ST(st));

  power_sample_ctrl #(.AVG_LOG2(0), .INTERVAL(10), .GO_CYC(GO_CYC), .TMO(TMO)) u_dut0 (
    .PT_CK(clk), .RESET_N(rst_n), .EN(en), .END_OK(end_ok), .DATA16(data16),
    .GO(go0), .SAMPLE(sample0), .SAMPLE_VLD(svld0), .AVG(avg0), .AVG_VLD(avld0),
    .MIN(mn0), .MAX(mx0), .TIMEOUT_ERR(terr0), .ST(st0));

  typedef struct { logic [15:0] val; int busy; } xfer_t;
  typedef struct { logic [15:0] avg; logic [15:0] mn; logic [15:0] mx; } avg_t;

  xfer_t       eng_q[$];
  logic [15:0] samp_q[$];
  avg_t        avg3_q[$];
  avg_t        avg0_q[$];
  int checks = 0, errors = 0, n_samp = 0, go_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic avg_t mk(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
    avg_t r;
    r.avg = a;
    r.mn  = MM ? lo : 16'h0;
    r.mx  = MM ? hi : 16'h0;
    return r;
  endfunction

  // ok=0: the engine answers but the DUT is expected to have timed out.
  task automatic push_x(input logic [15:0] v, input int busy, input bit ok);
    xfer_t x;
    x.val = v; x.busy = busy;
    eng_q.push_back(x);
    if (ok) begin
      samp_q.push_back(v);
      avg0_q.push_back(mk(v, v, v));
    end
  endtask

  // Engine model: END_OK low 3 cycles after GO falls, high again 'busy'
  // cycles later with the word on DATA16. Empty queue = engine never responds.
  initial begin
    xfer_t x;
    forever begin
      @(negedge clk);
      if (go && rst_n) begin
        while (go) @(negedge clk);
        if (rst_n && eng_q.size() > 0) begin
          x = eng_q.pop_front();
          repeat (2) @(negedge clk);
          end_ok = 1'b0;
          repeat (x.busy) @(negedge clk);
          data16 = x.val;
          end_ok = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    avg_t a;
    if (!rst_n) go_run = 0;
    else begin
      if (go) go_run++;
      else if (go_run != 0) begin
        chk("go_width", go_run, GO_CYC);
        go_run = 0;
      end
      if (svld) begin
        n_samp++;
        if (samp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sample_unexpected actual=%h required=none", sample);
        end else chk("sample", sample, samp_q.pop_front());
      end
      if (avld) begin
        chk("avg_vld_with_sample_vld", svld, 1);
        if (avg3_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL avg_unexpected actual=%h required=none", avg);
        end else begin
          a = avg3_q.pop_front();
          chk("avg", avg, a.avg);
          chk("min", mn, a.mn);
          chk("max", mx, a.mx);
        end
      end
      if (avld0) begin
        if (avg0_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL avg0_unexpected actual=%h required=none", avg0);
        end else begin
          a = avg0_q.pop_front();
          chk("avg0", avg0, a.avg);
          chk("min0", mn0, a.mn);
          chk("max0", mx0, a.mx);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_st(input string nm, input logic [2:0] s);
    int n = 0;
    while (st !== s && n < LIM) begin @(negedge clk); n++; end
    chk(nm, st, s);
  endtask

  task automatic wait_samp(input string nm, input int tgt);
    int n = 0;
    while (n_samp < tgt && n < LIM) begin @(negedge clk); n++; end
    chk(nm, n_samp, tgt);
  endtask

  // Run n conversions; EN drops two cycles into BUSY of the last one.
  task automatic run_drop(input string nm, input int n);
    int base = n_samp;
    en = 1'b1;
    if (n > 1) wait_samp({nm, "_pre"}, base + n - 1);
    wait_st({nm, "_busy"}, 3'd4);
    cyc(2);
    en = 1'b0;
    wait_samp({nm, "_samples"}, base + n);
    cyc(2);
    chk({nm, "_idle"}, st, 3'd0);
  endtask

  task automatic wait_err(input string nm, output int n);
    n = 0;
    while (terr !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk(nm, terr, 1);
  endtask

  initial begin
    int n;
    // reset state
    cyc(2);
    chk("rst_st", st, 0);    chk("rst_go", go, 0);
    chk("rst_sample", sample, 0); chk("rst_svld", svld, 0);
    chk("rst_avg", avg, 0);  chk("rst_avld", avld, 0);
    chk("rst_min", mn, 0);   chk("rst_max", mx, 0);
    chk("rst_err", terr, 0);
    rst_n = 1'b1;
    cyc(3);

    // A: 1-sample averaging boundary values
    push_x(16'hFFFF, 20, 1); push_x(16'h0001, 20, 1);
    run_drop("A", 2);
    // B: single basic conversion; window discarded by EN drop in BUSY
    push_x(16'h1234, 20, 1);
    run_drop("B", 1);
    chk("B_sample_hold", sample, 16'h1234);
    // C: 8-sample window 100..107 -> 103
    for (int i = 0; i < 8; i++) push_x(16'(100 + i), 20, 1);
    avg3_q.push_back(mk(16'd103, 16'd100, 16'd107));
    run_drop("C", 8);

    // D: partial window then REL timeout (engine never drops END_OK)
    push_x(16'd500, 20, 1); push_x(16'd600, 20, 1);
    n = n_samp;
    en = 1'b1;
    wait_samp("D_samples", n + 2);
    wait_st("D_rel", 3'd3);
    wait_err("D_err", n);
    chk("D_tmo_cycles", n, TMO);
    chk("D_idle", st, 3'd0);
    en = 1'b0;
    cyc(1);
    chk("D_err_clear", terr, 0);
    cyc(2);

    // E: fresh window after timeout discard: 10..80 -> 45
    for (int i = 1; i <= 8; i++) push_x(16'(10 * i), 20, 1);
    avg3_q.push_back(mk(16'd45, 16'd10, 16'd80));
    run_drop("E", 8);

    // F: END_OK rise exactly at expiry completes; one cycle later times out
    push_x(16'h0ABC, TMO, 1); push_x(16'h0DEF, TMO + 1, 0);
    n = n_samp;
    en = 1'b1;
    wait_samp("F_edge_sample", n + 1);
    chk("F_edge_no_err", terr, 0);
    wait_err("F_busy_err", n);
    chk("F_idle", st, 3'd0);
    en = 1'b0;
    cyc(3);
    chk("F_err_clear", terr, 0);
    chk("F_still_idle", st, 3'd0);

    // G: reset while GO high
    en = 1'b1;
    wait_st("G_go", 3'd2);
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("G_go_async", go, 0);   chk("G_st", st, 0);
    chk("G_sample", sample, 0); chk("G_avg", avg, 0);
    chk("G_min", mn, 0);        chk("G_max", mx, 0);
    chk("G_err", terr, 0);
    en = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // H: restart after reset
    push_x(16'h4321, 20, 1);
    run_drop("H", 1);

    chk("samp_q_left", samp_q.size(), 0);
    chk("avg3_q_left", avg3_q.size(), 0);
    chk("avg0_q_left", avg0_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/power_sample_ctrl.md
POWER_SAMPLE_CTRL -- requirements
Module: power_sample_ctrl

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, log2 of samples per average; legal range 0..6.
REQ-002 SHALL have parameter INTERVAL, default 1000, PT_CK cycles in WAIT between conversions; minimum 1.
REQ-003 SHALL have parameter GO_CYC, default 4, PT_CK cycles GO is held high per request.
REQ-004 SHALL have parameter TMO, default 4095, maximum PT_CK cycles allowed in REL or BUSY.
REQ-005 SHALL have port PT_CK  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port EN  in  1  run enable for periodic sampling.
REQ-008 SHALL have port END_OK  in  1  done/idle flag from the I2C read engine (high = idle/finished).
REQ-009 SHALL have port DATA16  in  16  read word from the I2C read engine, valid while END_OK high after a read.
REQ-010 SHALL have port GO  out  1  read request to the I2C read engine.
REQ-011 SHALL have ports SAMPLE  out  16  last raw word; SAMPLE_VLD  out  1  one-cycle pulse on update.
REQ-012 SHALL have ports AVG  out  16  windowed average; AVG_VLD  out  1  one-cycle pulse on update.
REQ-013 SHALL have ports MIN  out  16 and MAX  out  16  extremes of last completed window.
REQ-014 SHALL have port TIMEOUT_ERR  out  1  sticky handshake-timeout flag; ST  out  3  current state (test).

Function
REQ-015 SHALL implement states IDLE=0, WAIT=1, GO=2, REL=3, BUSY=4, CAP=5; ST shows the encoding.
REQ-016 IDLE: GO low; if EN and END_OK high, SHALL load interval counter and go to WAIT.
REQ-017 WAIT: SHALL count INTERVAL cycles then go to GO; EN low in WAIT SHALL return to IDLE next cycle.
REQ-018 GO: GO SHALL be high for exactly GO_CYC consecutive cycles, then state REL.
REQ-019 REL: GO low; END_OK low SHALL move to BUSY; TMO cycles without it SHALL set TIMEOUT_ERR and go to IDLE.
REQ-020 BUSY: END_OK high SHALL move to CAP; TMO cycles without it SHALL set TIMEOUT_ERR and go to IDLE.
REQ-021 Timeout counter SHALL clear on entry to REL and to BUSY.
REQ-022 CAP (one cycle): SAMPLE<=DATA16, SAMPLE_VLD pulses, accumulator += DATA16, sample count +1.
REQ-023 Accumulator SHALL be 16+AVG_LOG2 bits unsigned, never overflowing.
REQ-024 When count reaches 2^AVG_LOG2 in CAP, AVG SHALL take accumulator-including-this-sample >> AVG_LOG2 (truncate), AVG_VLD pulses same cycle as SAMPLE_VLD; accumulator and count clear.
REQ-025 After CAP: EN high -> WAIT (interval reloaded); EN low -> IDLE with partial accumulator and count discarded.
REQ-026 EN falling during GO/REL/BUSY SHALL NOT abort; conversion completes through CAP.
REQ-027 TIMEOUT_ERR SHALL clear only in IDLE while EN low, or by reset; a timeout SHALL discard the partial window.
REQ-028 Simultaneous END_OK rise and timeout expiry in BUSY SHALL resolve as completion (CAP), no error.

Reset
REQ-029 On RESET_N low, state IDLE, GO=0, SAMPLE=0, AVG=0, MIN=0, MAX=0, SAMPLE_VLD=0, AVG_VLD=0, TIMEOUT_ERR=0, accumulator/count/counters=0, immediately.
REQ-030 Reset mid-conversion SHALL drop GO the same instant; no sample is produced for that conversion.

Configuration
REQ-031 Macro PSC_MINMAX_EN defined: window min/max registers (start 16'hFFFF/16'h0000 per window) update in CAP; MIN/MAX load at AVG_VLD.
REQ-032 Macro PSC_MINMAX_EN undefined: no min/max registers; MIN and MAX tied to 0.

Verification
REQ-033 INTERVAL=10, GO_CYC=4, model replies END_OK low 3 cycles after GO falls, high 20 later with 16'h1234 -> GO high exactly 4 cycles, SAMPLE=16'h1234, one SAMPLE_VLD.
REQ-034 AVG_LOG2=3, eight samples 100..107 -> AVG_VLD once on eighth CAP, AVG=103; with PSC_MINMAX_EN MIN=100, MAX=107.
REQ-035 Model never drops END_OK, TMO=50 -> TIMEOUT_ERR set 50 cycles after entering REL, state IDLE; EN low clears it.
REQ-036 EN dropped two cycles into BUSY -> conversion completes, SAMPLE_VLD pulses, state IDLE, no AVG_VLD, count reset.
REQ-037 RESET_N asserted while GO high -> GO low asynchronously, all outputs at reset values, restart from IDLE after release.
REQ-038 AVG_LOG2=0, samples 16'hFFFF then 16'h0001 -> AVG_VLD every sample, AVG=16'hFFFF then 16'h0001.
